seg7_scan_display: RTL and testbench

//  Downstream consumer of the pipeline processor's 32-bit fpga debug output.

---
 rtl/seg7_scan_display.sv | 119 +++++++++++
 tb/tb_seg7_scan_display.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_display.sv
// Multiplexed common-anode hex display driver with tear-free frame latch and inter-digit blanking.
// Optional LEADING_ZERO_BLANK_EN: suppress leading-zero digits (digit 0 always shown).
module seg7_scan_display #(
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned BLANK_CYC   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       data_in,
    output logic [DIGITS-1:0] anode,
    output logic [6:0]        seg,
    output logic              dp,
    output logic              frame
);

    localparam int unsigned DIV_W = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [DIV_W-1:0]  div_cnt;
    logic [IDX_W-1:0]  dig_idx;
    logic [31:0]       shown;

    logic [DIV_W-1:0]  div_nx;
    logic [IDX_W-1:0]  idx_nx;
    logic [31:0]       shown_nx;
    logic [DIV_W-1:0]  blank_lim;
    logic              tc;
    logic              latch;
    logic              blank_nx;
    logic              lz_blank;
    logic [DIGITS-1:0] anode_nx;
    logic [6:0]        seg_nx;

    assign blank_lim = DIV_W'(BLANK_CYC);

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;
            4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;
            4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;
            4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;
            4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;
            4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;
            4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;
            4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;
            4'hF: hex7 = 7'h0E;
        endcase
    endfunction

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd;
    logic [IDX_W-1:0] msd_nx;

    // Index of the highest nonzero displayed nibble, 0 when all are zero.
    function automatic logic [IDX_W-1:0] msd_of(input logic [31:0] v);
        msd_of = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] != 4'h0) msd_of = IDX_W'(i);
        end
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) msd <= '0;
        else      msd <= msd_nx;
    end
`endif

    // Next scan state; outputs are derived from it so they land one cycle later, registered.
    always_comb begin
        tc       = (div_cnt == DIV_W'(REFRESH_DIV - 1));
        div_nx   = tc ? '0 : div_cnt + DIV_W'(1);
        idx_nx   = dig_idx;
        latch    = tc && (dig_idx == IDX_W'(DIGITS - 1));
        if (tc) idx_nx = latch ? '0 : dig_idx + IDX_W'(1);
        shown_nx = latch ? data_in : shown;
`ifdef LEADING_ZERO_BLANK_EN
        msd_nx   = latch ? msd_of(data_in) : msd;
        lz_blank = (idx_nx > msd_nx);
`else
        lz_blank = 1'b0;
`endif
        blank_nx = (div_nx < blank_lim) || lz_blank;
        anode_nx = ~(DIGITS'(1) << idx_nx);
        seg_nx   = hex7(shown_nx[4*idx_nx +: 4]);
        if (blank_nx) begin
            anode_nx = '1;
            seg_nx   = 7'h7F;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt <= '0;
            dig_idx <= '0;
            shown   <= 32'h0;
            anode   <= '1;
            seg     <= 7'h7F;
            dp      <= 1'b1;
            frame   <= 1'b0;
        end else begin
            div_cnt <= div_nx;
            dig_idx <= idx_nx;
            shown   <= shown_nx;
            anode   <= anode_nx;
            seg     <= seg_nx;
            dp      <= 1'b1;
            frame   <= latch;
        end
    end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: main instance (DIV=4, BLANK=1) plus a DIV=2, BLANK=0 instance.
module tb_seg7_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [7:0]  anode, b_anode;
    logic [6:0]  seg, b_seg;
    logic        dp, b_dp, frame, b_frame;

    int checks = 0;
    int errors = 0;
    int k      = 0;
    int base   = 0;

    typedef struct {
        int         k;
        logic [7:0] an;
        logic [6:0] sg;
        logic       fr;
        logic [7:0] b_an;
        logic       b_fr;
    } sb_t;

    sb_t        q[$];
    logic [6:0] segtab [7][8];
    logic [7:0] littab [7];

    always #5 clk = ~clk;

    seg7_scan_display #(.DIGITS(8), .REFRESH_DIV(4), .BLANK_CYC(1)) dut (
        .clk(clk), .rst(rst), .data_in(data_in),
        .anode(anode), .seg(seg), .dp(dp), .frame(frame)
    );

    seg7_scan_display #(.DIGITS(8), .REFRESH_DIV(2), .BLANK_CYC(0)) dut_b (
        .clk(clk), .rst(rst), .data_in(data_in),
        .anode(b_anode), .seg(b_seg), .dp(b_dp), .frame(b_frame)
    );

    task automatic chk(input string nm, input int kk, input logic [7:0] act, input logic [7:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s k=%0d got %h expected %h", nm, kk, act, exp_v);
        end
    endtask

    task automatic set_row(input int r, input logic [55:0] s, input logic [7:0] lit);
        for (int i = 0; i < 8; i++) segtab[r][i] = s[7*i +: 7];
        littab[r] = lit;
    endtask

    task automatic rstep();
        sb_t e;
        @(posedge clk); #1;
        e.k = -1; e.an = 8'hFF; e.sg = 7'h7F; e.fr = 1'b0; e.b_an = 8'hFF; e.b_fr = 1'b0;
        q.push_back(e);
    endtask

    // Expected outputs for cycle k after release, from the hand-written per-frame tables.
    task automatic step();
        sb_t e;
        int  d;
        int  r;
        @(posedge clk); #1;
        k++;
        e.k = k;
        e.an = 8'hFF;
        e.sg = 7'h7F;
        if (k % 4 != 0) begin
            d = (k / 4) % 8;
            r = base + k / 32;
            if (littab[r][d]) begin
                e.an = ~(8'h01 << d);
                e.sg = segtab[r][d];
            end
        end
        e.fr   = (k % 32 == 0);
        e.b_an = ~(8'h01 << ((k / 2) % 8));
        e.b_fr = (k % 16 == 0);
        q.push_back(e);
    endtask

    initial begin
        sb_t e;
        forever begin
            @(negedge clk);
            while (q.size() != 0) begin
                e = q.pop_front();
                chk("anode",   e.k, anode,            e.an);
                chk("seg",     e.k, {1'b0, seg},      {1'b0, e.sg});
                chk("dp",      e.k, {7'h0, dp},       8'h01);
                chk("frame",   e.k, {7'h0, frame},    {7'h0, e.fr});
                chk("b_anode", e.k, b_anode,          e.b_an);
                chk("b_frame", e.k, {7'h0, b_frame},  {7'h0, e.b_fr});
                chk("b_dp",    e.k, {7'h0, b_dp},     8'h01);
            end
        end
    end

    initial begin
        logic [7:0] lz;
`ifdef LEADING_ZERO_BLANK_EN
        lz = 8'h01;
`else
        lz = 8'hFF;
`endif
        // digit 7 .. digit 0
        set_row(0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, lz);
        set_row(1, {7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E}, 8'hFF);
        set_row(2, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79}, lz);
`ifdef LEADING_ZERO_BLANK_EN
        set_row(3, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12}, 8'h03);
`else
        set_row(3, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h08, 7'h12}, 8'hFF);
`endif
        set_row(4, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, lz);
        set_row(5, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, lz);
        set_row(6, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00}, 8'hFF);

        rst     = 1'b0;
        data_in = 32'h89AB_CDEF;
        repeat (5) rstep();
        #1 rst = 1'b1;
        k    = 0;
        base = 0;

        while (k < 45)  step();
        data_in = 32'h0000_0001;
        while (k < 70)  step();
        data_in = 32'h0000_00A5;
        while (k < 100) step();
        data_in = 32'h0000_0000;
        while (k < 150) step();

        // Async reset mid-slot: outputs must clear before the next clock edge.
        @(negedge clk); #1;
        rst = 1'b0;
        #1;
        chk("async_anode",   k, anode,           8'hFF);
        chk("async_seg",     k, {1'b0, seg},     8'h7F);
        chk("async_dp",      k, {7'h0, dp},      8'h01);
        chk("async_frame",   k, {7'h0, frame},   8'h00);
        chk("async_b_anode", k, b_anode,         8'hFF);
        chk("async_b_frame", k, {7'h0, b_frame}, 8'h00);
        data_in = 32'h1234_5678;
        repeat (3) rstep();
        #1 rst = 1'b1;
        k    = 0;
        base = 5;
        while (k < 64) step();

        @(negedge clk); #1;
        chk("queue_drained", 0, 8'(q.size()), 8'h00);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
